// File: rtl/ym3438_timers_if.sv
//------------------------------------------------------------------------------
// Module      : ym3438_timers_if
// Description : Register/strobe inputs and status outputs of the OPN2 timer block.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ym3438_timers_if;
    logic       c1;
    logic       timer_ed;
    logic [9:0] ta;
    logic [7:0] tb;
    logic [5:0] reg_27;
    logic       write_27;
    logic       timer_a;
    logic       timer_b;
    logic       timer_a_ovf;
    logic       irq;

    modport master (
        output c1, timer_ed, ta, tb, reg_27, write_27,
        input  timer_a, timer_b, timer_a_ovf, irq
    );

    modport slave (
        input  c1, timer_ed, ta, tb, reg_27, write_27,
        output timer_a, timer_b, timer_a_ovf, irq
    );
endinterface

`default_nettype wire

// File: rtl/ym3438_timers.sv
//------------------------------------------------------------------------------
// Module      : ym3438_timers
// Description : OPN2 Timer A / Timer B counters, status flags, overflow pulse, IRQ.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ym3438_timers (
    input  wire logic     MCLK,
    input  wire logic     IC,
    ym3438_timers_if.slave bus
);

    localparam logic [9:0] c_CNT_A_MAX = 10'h3FF;
    localparam logic [7:0] c_CNT_B_MAX = 8'hFF;
    localparam logic [3:0] c_PRESC_TC  = 4'hF;

    logic [9:0] r_cnt_a;
    logic [7:0] r_cnt_b;
    logic [3:0] r_presc_b;
    logic       r_load_a_d;
    logic       r_load_b_d;
    logic       r_flag_a;
    logic       r_flag_b;
    logic       r_ovf_a;
    logic       r_irq;

    logic       w_slot;
    logic       w_tick;
    logic       w_load_a;
    logic       w_load_b;
    logic       w_load_a_edge;
    logic       w_load_b_edge;
    logic       w_presc_tc;
    logic       w_ovf_a;
    logic       w_ovf_b;
    logic [9:0] w_cnt_a_nxt;
    logic [7:0] w_cnt_b_nxt;
    logic       w_flag_a_nxt;
    logic       w_flag_b_nxt;

    assign w_slot        = bus.c1;
    assign w_tick        = bus.c1 & bus.timer_ed;
    assign w_load_a      = bus.reg_27[0];
    assign w_load_b      = bus.reg_27[1];
    assign w_load_a_edge = w_load_a & ~r_load_a_d;
    assign w_load_b_edge = w_load_b & ~r_load_b_d;
    assign w_presc_tc    = (r_presc_b == c_PRESC_TC);

    // A load edge takes priority over counting, so the reload tick never overflows.
    assign w_ovf_a = w_tick & w_load_a & r_load_a_d & (r_cnt_a == c_CNT_A_MAX);
    assign w_ovf_b = w_tick & w_load_b & r_load_b_d & w_presc_tc
                   & (r_cnt_b == c_CNT_B_MAX);

    always_comb begin
        w_cnt_a_nxt = r_cnt_a;
        if (w_tick && w_load_a) begin
            if (w_load_a_edge || w_ovf_a) begin
                w_cnt_a_nxt = bus.ta;
            end else begin
                w_cnt_a_nxt = r_cnt_a + 10'd1;
            end
        end
    end

    // Timer B reload edge is seen on every tick; only counting waits for the prescaler.
    always_comb begin
        w_cnt_b_nxt = r_cnt_b;
        if (w_tick && w_load_b) begin
            if (w_load_b_edge || w_ovf_b) begin
                w_cnt_b_nxt = bus.tb;
            end else if (w_presc_tc) begin
                w_cnt_b_nxt = r_cnt_b + 8'd1;
            end
        end
    end

    // Clear is applied first so a same-tick overflow set wins.
    always_comb begin
        w_flag_a_nxt = r_flag_a;
        w_flag_b_nxt = r_flag_b;
        if (w_slot && bus.write_27 && bus.reg_27[4]) begin
            w_flag_a_nxt = 1'b0;
        end
        if (w_slot && bus.write_27 && bus.reg_27[5]) begin
            w_flag_b_nxt = 1'b0;
        end
        if (w_ovf_a && bus.reg_27[2]) begin
            w_flag_a_nxt = 1'b1;
        end
        if (w_ovf_b && bus.reg_27[3]) begin
            w_flag_b_nxt = 1'b1;
        end
    end

    always_ff @(posedge MCLK or posedge IC) begin
        if (IC) begin
            r_cnt_a    <= 10'd0;
            r_cnt_b    <= 8'd0;
            r_presc_b  <= 4'd0;
            r_load_a_d <= 1'b0;
            r_load_b_d <= 1'b0;
        end else if (w_tick) begin
            r_cnt_a    <= w_cnt_a_nxt;
            r_cnt_b    <= w_cnt_b_nxt;
            r_presc_b  <= r_presc_b + 4'd1;
            r_load_a_d <= w_load_a;
            r_load_b_d <= w_load_b;
        end
    end

    always_ff @(posedge MCLK or posedge IC) begin
        if (IC) begin
            r_flag_a <= 1'b0;
            r_flag_b <= 1'b0;
            r_ovf_a  <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            r_flag_a <= w_flag_a_nxt;
            r_flag_b <= w_flag_b_nxt;
            r_irq    <= w_flag_a_nxt | w_flag_b_nxt;
            if (w_slot) begin
                r_ovf_a <= w_ovf_a;
            end
        end
    end

    assign bus.timer_a     = r_flag_a;
    assign bus.timer_b     = r_flag_b;
    assign bus.timer_a_ovf = r_ovf_a;
    assign bus.irq         = r_irq;

endmodule

`default_nettype wire

// File: tb/tb_ym3438_timers.sv
//------------------------------------------------------------------------------
// Module      : tb_ym3438_timers
// Description : Self-checking bench for ym3438_timers against a tick-count model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_ym3438_timers;

    logic MCLK = 1'b0;
    logic IC   = 1'b1;
    always #5 MCLK = ~MCLK;

    ym3438_timers_if bus ();

    ym3438_timers dut (
        .MCLK (MCLK),
        .IC   (IC),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: ticks remaining until overflow, plus a global tick count for the prescaler phase.
    int m_rem_a, m_rem_b, m_ticks;
    bit m_prev_a, m_prev_b, m_flag_a, m_flag_b, m_ovf, m_irq;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_rem_a  = 0;
        m_rem_b  = 0;
        m_ticks  = 0;
        m_prev_a = 1'b0;
        m_prev_b = 1'b0;
        m_flag_a = 1'b0;
        m_flag_b = 1'b0;
        m_ovf    = 1'b0;
        m_irq    = 1'b0;
    endtask

    task automatic model_step();
        bit tick, ovfa, ovfb;
        tick = bus.c1 && bus.timer_ed;
        ovfa = 1'b0;
        ovfb = 1'b0;
        if (tick) begin
            if (bus.reg_27[0]) begin
                if (!m_prev_a) m_rem_a = 1024 - int'(bus.ta);
                else begin
                    m_rem_a--;
                    if (m_rem_a == 0) begin
                        ovfa    = 1'b1;
                        m_rem_a = 1024 - int'(bus.ta);
                    end
                end
            end
            m_prev_a = bus.reg_27[0];
            if (bus.reg_27[1]) begin
                if (!m_prev_b) m_rem_b = 256 - int'(bus.tb);
                else if (m_ticks % 16 == 15) begin
                    m_rem_b--;
                    if (m_rem_b == 0) begin
                        ovfb    = 1'b1;
                        m_rem_b = 256 - int'(bus.tb);
                    end
                end
            end
            m_prev_b = bus.reg_27[1];
            m_ticks++;
        end
        if (bus.c1) begin
            if (bus.write_27 && bus.reg_27[4]) m_flag_a = 1'b0;
            if (bus.write_27 && bus.reg_27[5]) m_flag_b = 1'b0;
            if (ovfa && bus.reg_27[2]) m_flag_a = 1'b1;
            if (ovfb && bus.reg_27[3]) m_flag_b = 1'b1;
            m_ovf = ovfa;
        end
        m_irq = m_flag_a | m_flag_b;
    endtask

    always @(negedge MCLK) begin
        if (chk_en) begin
            chk("cmp_timer_a", int'(bus.timer_a), int'(m_flag_a));
            chk("cmp_timer_b", int'(bus.timer_b), int'(m_flag_b));
            chk("cmp_ovf_a", int'(bus.timer_a_ovf), int'(m_ovf));
            chk("cmp_irq", int'(bus.irq), int'(m_irq));
        end
    end

    // Inputs change at negedge; DUT and model both consume them at the next posedge.
    task automatic step();
        @(posedge MCLK);
        if (IC) model_reset();
        else model_step();
        @(negedge MCLK);
    endtask

    task automatic ticks(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            bus.c1       = 1'b1;
            bus.write_27 = 1'b0;
            bus.timer_ed = 1'b0;
            repeat (gap - 1) step();
            bus.timer_ed = 1'b1;
            step();
            bus.timer_ed = 1'b0;
        end
    endtask

    task automatic async_reset();
        #2;
        IC = 1'b1;
        model_reset();
        #1;
        @(negedge MCLK);
        step();
        IC = 1'b0;
    endtask

    task automatic do_reset();
        bus.reg_27   = 6'h00;
        bus.write_27 = 1'b0;
        bus.timer_ed = 1'b0;
        bus.c1       = 1'b1;
        async_reset();
        step();
    endtask

    initial begin
        bus.c1       = 1'b1;
        bus.timer_ed = 1'b0;
        bus.ta       = 10'd0;
        bus.tb       = 8'd0;
        bus.reg_27   = 6'h00;
        bus.write_27 = 1'b0;
        model_reset();
        @(negedge MCLK);
        step();
        IC = 1'b0;
        chk("reset_timer_a", int'(bus.timer_a), 0);
        chk("reset_irq", int'(bus.irq), 0);
        chk_en = 1'b1;

        // Timer A period, ta=1020 -> 4 ticks per overflow
        do_reset();
        bus.ta = 10'd1020;
        bus.reg_27 = 6'h05;
        ticks(1, 24);
        ticks(3, 24);
        chk("a_before_ovf", int'(bus.timer_a), 0);
        ticks(1, 24);
        chk("a_flag_set", int'(bus.timer_a), 1);
        chk("a_irq_set", int'(bus.irq), 1);
        chk("a_ovf_pulse", int'(bus.timer_a_ovf), 1);
        step();
        chk("a_ovf_width", int'(bus.timer_a_ovf), 0);
        ticks(3, 4);
        chk("a_ovf_gap", int'(bus.timer_a_ovf), 0);
        ticks(1, 4);
        chk("a_ovf_period", int'(bus.timer_a_ovf), 1);

        // Flag disabled, ta=1023 overflows every tick
        do_reset();
        bus.ta = 10'd1023;
        bus.reg_27 = 6'h01;
        ticks(2, 4);
        chk("a1023_ovf", int'(bus.timer_a_ovf), 1);
        chk("a1023_noflag", int'(bus.timer_a), 0);
        ticks(1, 4);
        chk("a1023_ovf_again", int'(bus.timer_a_ovf), 1);
        bus.reg_27 = 6'h05;
        ticks(1, 4);
        chk("a1023_flag_on", int'(bus.timer_a), 1);
        bus.reg_27 = 6'h15;
        bus.write_27 = 1'b1;
        step();
        bus.write_27 = 1'b0;
        bus.reg_27 = 6'h05;
        chk("a_flag_cleared", int'(bus.timer_a), 0);
        ticks(1, 4);
        chk("a_flag_reset_again", int'(bus.timer_a), 1);

        // Timer B, tb=254 loaded at prescaler phase 0 -> 32 ticks
        do_reset();
        bus.tb = 8'd254;
        bus.reg_27 = 6'h0A;
        ticks(31, 2);
        chk("b_before_ovf", int'(bus.timer_b), 0);
        ticks(1, 2);
        chk("b_flag_set", int'(bus.timer_b), 1);
        chk("b_a_quiet", int'(bus.timer_a), 0);
        chk("b_irq", int'(bus.irq), 1);
        bus.reg_27 = 6'h20;
        bus.write_27 = 1'b1;
        step();
        bus.write_27 = 1'b0;
        step();
        chk("b_cleared", int'(bus.timer_b), 0);
        chk("b_irq_cleared", int'(bus.irq), 0);

        // Clear A in the same tick as an overflow
        do_reset();
        bus.ta = 10'd1022;
        bus.reg_27 = 6'h05;
        ticks(3, 3);
        chk("sim_first_ovf", int'(bus.timer_a), 1);
        ticks(1, 3);
        step();
        step();
        bus.reg_27 = 6'h15;
        bus.write_27 = 1'b1;
        bus.timer_ed = 1'b1;
        step();
        bus.timer_ed = 1'b0;
        bus.write_27 = 1'b0;
        chk("sim_set_wins", int'(bus.timer_a), 1);
        chk("sim_ovf", int'(bus.timer_a_ovf), 1);
        bus.write_27 = 1'b1;
        step();
        bus.write_27 = 1'b0;
        bus.reg_27 = 6'h05;
        chk("sim_plain_clear", int'(bus.timer_a), 0);

        // Stop, hold, reload
        do_reset();
        bus.ta = 10'd1020;
        bus.reg_27 = 6'h05;
        ticks(3, 3);
        bus.reg_27 = 6'h04;
        ticks(10, 3);
        chk("stop_no_ovf", int'(bus.timer_a), 0);
        bus.reg_27 = 6'h05;
        ticks(4, 3);
        chk("reload_before", int'(bus.timer_a), 0);
        ticks(1, 3);
        chk("reload_period", int'(bus.timer_a), 1);

        // Asynchronous reset between edges with flag set
        bus.reg_27 = 6'h0F;
        bus.tb = 8'd255;
        ticks(40, 2);
        #2;
        IC = 1'b1;
        model_reset();
        #1;
        chk("ic_timer_a", int'(bus.timer_a), 0);
        chk("ic_timer_b", int'(bus.timer_b), 0);
        chk("ic_ovf", int'(bus.timer_a_ovf), 0);
        chk("ic_irq", int'(bus.irq), 0);
        @(negedge MCLK);
        step();
        IC = 1'b0;
        bus.reg_27 = 6'h05;
        bus.ta = 10'd1020;
        ticks(4, 3);
        chk("post_ic_before", int'(bus.timer_a), 0);
        ticks(1, 3);
        chk("post_ic_ovf", int'(bus.timer_a), 1);

        // Randomized traffic checked every cycle by the compare process
        for (int i = 0; i < 6000; i++) begin
            bus.c1       = ($urandom_range(0, 9) < 8);
            bus.timer_ed = ($urandom_range(0, 3) == 0);
            bus.write_27 = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 9) == 0) bus.reg_27 = 6'($urandom_range(0, 63));
            if ($urandom_range(0, 49) == 0) bus.ta = 10'($urandom_range(1016, 1023));
            if ($urandom_range(0, 49) == 0) bus.tb = 8'($urandom_range(250, 255));
            if ($urandom_range(0, 1499) == 0) async_reset();
            else step();
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
